test_system: RTL and testbench

- Self-contained demonstration top level for the 16-bit multi-register accumulator processor.
- Integrates an internal fixed program ROM, PC, accumulator, 8-entry register file and an output register, all on one clock.
- Only visible result is Output_Data, driven by OUT instructions; used as the system-level smoke test of the processor.

---
 rtl/test_system_if.sv | 14 +
 rtl/test_system.sv | 139 +++++++++++++
 tb/tb_test_system.sv | 122 ++++++++++++
 3 files changed

// File: rtl/test_system_if.sv
// Output bundle of the accumulator demo system: the OUT register and, with
// HALT_FLAG_EN defined, the halted status flag.
interface test_system_if;
  logic [15:0] Output_Data;
`ifdef HALT_FLAG_EN
  logic        Halted;

  modport master (output Output_Data, output Halted);
  modport slave  (input  Output_Data, input  Halted);
`else
  modport master (output Output_Data);
  modport slave  (input  Output_Data);
`endif
endinterface

// File: rtl/test_system.sv
// Single-cycle 16-bit accumulator processor with a fixed demo program in ROM.
// Optional macro HALT_FLAG_EN exposes the internal halted register on the bus.
module test_system #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic          Clock,
  input  logic          Reset,
  test_system_if.master bus
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LDR  = 4'h2,
    OP_STR  = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_JMP  = 4'hA,
    OP_BEZ  = 4'hB,
    OP_BNZ  = 4'hC,
    OP_OUT  = 4'hD,
    OP_ADDI = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef struct packed {
    opcode_t     op;
    logic [11:0] operand;
  } instr_t;

  logic [7:0]  pc;
  logic [15:0] acc;
  logic [15:0] regs [8];
  logic [15:0] out_q;
  logic        halted;

  instr_t      instr;
  logic [2:0]  r_sel;
  logic [15:0] r_val;
  logic [15:0] imm;
  logic [3:0]  shamt;
  logic [7:0]  target;

  logic [7:0]  pc_next;
  logic [15:0] acc_next;
  logic        reg_we;
  logic        out_we;
  logic        halt_set;

  // Fixed program: counts R2 down from 5, accumulating the running sum into R1
  // and emitting it, then emits the final sum shifted left by 4 and halts.
  always_comb begin
    unique case (pc)
      8'd0:    instr = 16'h1000;
      8'd1:    instr = 16'h3001;
      8'd2:    instr = 16'h1005;
      8'd3:    instr = 16'h3002;
      8'd4:    instr = 16'h2001;
      8'd5:    instr = 16'h4002;
      8'd6:    instr = 16'h3001;
      8'd7:    instr = 16'hD000;
      8'd8:    instr = 16'h2002;
      8'd9:    instr = 16'hEFFF;
      8'd10:   instr = 16'h3002;
      8'd11:   instr = 16'hC004;
      8'd12:   instr = 16'h2001;
      8'd13:   instr = 16'h8004;
      8'd14:   instr = 16'hD000;
      8'd15:   instr = 16'hF000;
      default: instr = 16'h0000;
    endcase
  end

  assign r_sel  = instr.operand[2:0];
  assign r_val  = regs[r_sel];
  assign imm    = {{4{instr.operand[11]}}, instr.operand};
  assign shamt  = instr.operand[3:0];
  assign target = instr.operand[7:0];

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    pc_next  = pc + 8'd1;
    acc_next = acc;
    reg_we   = 1'b0;
    out_we   = 1'b0;
    halt_set = 1'b0;
    unique case (instr.op)
      OP_NOP:  ;
      OP_LDI:  acc_next = imm;
      OP_LDR:  acc_next = r_val;
      OP_STR:  reg_we   = 1'b1;
      OP_ADD:  acc_next = acc + r_val;
      OP_SUB:  acc_next = acc - r_val;
      OP_AND:  acc_next = acc & r_val;
      OP_OR:   acc_next = acc | r_val;
      OP_SHL:  acc_next = acc << shamt;
      OP_SHR:  acc_next = acc >> shamt;
      OP_JMP:  pc_next  = target;
      OP_BEZ:  if (acc == 16'd0) pc_next = target;
      OP_BNZ:  if (acc != 16'd0) pc_next = target;
      OP_OUT:  out_we   = 1'b1;
      OP_ADDI: acc_next = acc + imm;
      OP_HALT: halt_set = 1'b1;
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, matching single-cycle commit semantics.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc     <= RESET_PC;
      acc    <= 16'd0;
      out_q  <= 16'd0;
      halted <= 1'b0;
      // NOTE: the register file is reset explicitly because the program reads
      // nothing it has not written, but R0..R7 must still be defined at reset;
      // this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
    end else if (!halted) begin
      pc     <= pc_next;
      acc    <= acc_next;
      halted <= halt_set;
      if (out_we) out_q       <= acc;
      if (reg_we) regs[r_sel] <= acc;
    end
  end

  assign bus.Output_Data = out_q;
`ifdef HALT_FLAG_EN
  assign bus.Halted      = halted;
`endif

endmodule

// File: tb/tb_test_system.sv
// Directed bench for test_system: checks the demo program's output sequence,
// halt behaviour and asynchronous reset, with hand-computed expected values.
module tb_test_system;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  test_system_if bus ();

  test_system #(.RESET_PC(8'h00)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #10 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Output_Data after edge e counted from reset release.
  function automatic logic [15:0] expected_out(input int e);
    if (e < 8)       return 16'h0000;
    else if (e < 16) return 16'h0005;
    else if (e < 24) return 16'h0009;
    else if (e < 32) return 16'h000C;
    else if (e < 40) return 16'h000E;
    else if (e < 47) return 16'h000F;
    else             return 16'h00F0;
  endfunction

  // Runs edges 1..last after reset release, checking every edge.
  task automatic run_edges(input string phase, input int last);
    for (int e = 1; e <= last; e++) begin
      @(posedge Clock);
      #1;
      check($sformatf("%s_out_e%0d", phase, e), bus.Output_Data, expected_out(e));
`ifdef HALT_FLAG_EN
      check($sformatf("%s_halt_e%0d", phase, e), {15'd0, bus.Halted},
            {15'd0, e >= 48});
`endif
    end
  endtask

  task automatic release_reset();
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock);
      #1;
      check($sformatf("rst_hold_%0d", i), bus.Output_Data, 16'h0000);
`ifdef HALT_FLAG_EN
      check($sformatf("rst_hold_halt_%0d", i), {15'd0, bus.Halted}, 16'd0);
`endif
    end

    // Full program run, then 100 frozen edges.
    release_reset();
    run_edges("run1", 48);
    for (int i = 0; i < 100; i++) begin
      @(posedge Clock);
      #1;
      if (i % 10 == 9) begin
        check($sformatf("frozen_%0d", i), bus.Output_Data, 16'h00F0);
`ifdef HALT_FLAG_EN
        check($sformatf("frozen_halt_%0d", i), {15'd0, bus.Halted}, 16'd1);
`endif
      end
    end

    // Reset after HALT, asserted between edges: clears at once.
    #5;
    Reset = 1'b1;
    #1;
    check("rst_after_halt", bus.Output_Data, 16'h0000);
`ifdef HALT_FLAG_EN
    check("rst_after_halt_flag", {15'd0, bus.Halted}, 16'd0);
`endif
    release_reset();
    run_edges("run2", 48);

    // Reset mid-program between edges 20 and 21.
    #5;
    Reset = 1'b1;
    release_reset();
    run_edges("run3_pre", 20);
    check("mid_before_rst", bus.Output_Data, 16'h0009);
    #5;
    Reset = 1'b1;
    #1;
    check("mid_rst_async", bus.Output_Data, 16'h0000);
    release_reset();
    run_edges("run3", 48);
    repeat (5) @(posedge Clock);
    #1;
    check("final_value", bus.Output_Data, 16'h00F0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
